// File: rtl/register_status_file_pkg.sv
// register_status_file_pkg: shared widths, constants and tag-match helper.
package register_status_file_pkg;
  localparam int REG_NUM = 32;
  localparam int ENTRY_W = 5;
  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  function automatic logic tag_hit(input logic busy, input logic [ENTRY_W-1:0] a, input logic [ENTRY_W-1:0] b);
    return busy && (a == b);
  endfunction
endpackage

// File: rtl/register_status_file_reg_read_port.sv
// reg_read_port: combinational operand read with commit forwarding.
module reg_read_port
  import register_status_file_pkg::*;
(
  input  logic [REG_W-1:0]   i_addr,
  input  logic [XLEN-1:0]    i_reg_val,
  input  logic               i_busy,
  input  logic [ENTRY_W-1:0] i_tag,
  input  logic               i_commit,
  input  logic [REG_W-1:0]   i_commit_rd,
  input  logic [ENTRY_W-1:0] i_commit_entry,
  input  logic [XLEN-1:0]    i_commit_val,
  output logic [XLEN-1:0]    o_value,
  output logic               o_busy,
  output logic [ENTRY_W-1:0] o_tag
);
  logic w_zero, w_fwd;
  assign w_zero = i_addr == '0;
  // forward only when the committing entry is the register's current producer
  assign w_fwd  = i_commit && (i_commit_rd == i_addr) && tag_hit(i_busy, i_tag, i_commit_entry);
  always_comb begin
    o_value = w_zero ? '0 : w_fwd ? i_commit_val : i_reg_val;
    o_busy  = !w_zero && i_busy && !w_fwd;
    o_tag   = o_busy ? i_tag : '0;
  end
endmodule

// File: rtl/register_status_file.sv
// register_status_file: architectural registers with per-register rename tags.
module register_status_file
  import register_status_file_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  input  logic               issue_valid,
  input  logic [REG_W-1:0]   issue_rd,
  input  logic [ENTRY_W-1:0] issue_entry,
  input  logic [REG_W-1:0]   rs1_addr,
  input  logic [REG_W-1:0]   rs2_addr,
  output logic [XLEN-1:0]    rs1_value,
  output logic [XLEN-1:0]    rs2_value,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic [ENTRY_W-1:0] rs1_tag,
  output logic [ENTRY_W-1:0] rs2_tag,
  input  logic               rob_commit,
  input  logic [5:0]         rob_des_commit,
  input  logic [ENTRY_W-1:0] rob_entry_commit,
  input  logic [XLEN-1:0]    rob_result_out
);
  logic [XLEN-1:0]    r_regs [REG_NUM];
  logic [ENTRY_W-1:0] r_tag  [REG_NUM];
  logic [REG_NUM-1:0] r_busy;
  logic [REG_W-1:0]   w_crd;
  logic               w_commit, w_cwr, w_issue, w_unused;
  assign w_crd    = rob_des_commit[REG_W-1:0];
  assign w_unused = rob_des_commit[5];
  assign w_commit = rdy_in && rob_commit;
  assign w_cwr    = w_commit && (w_crd != '0);
  assign w_issue  = issue_valid && (issue_rd != '0);
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (w_cwr) r_regs[w_crd] <= rob_result_out;
      if (roll_back) r_busy <= '0;
      else begin
        // issue is applied after the clear so a same-rd issue keeps the register busy
        if (w_cwr && tag_hit(r_busy[w_crd], r_tag[w_crd], rob_entry_commit)) r_busy[w_crd] <= FALSE;
        if (w_issue) begin
          r_busy[issue_rd] <= TRUE;
          r_tag[issue_rd]  <= issue_entry;
        end
      end
    end
  end
  reg_read_port u_rs1 (
    .i_addr(rs1_addr), .i_reg_val(r_regs[rs1_addr]), .i_busy(r_busy[rs1_addr]), .i_tag(r_tag[rs1_addr]),
    .i_commit(w_commit), .i_commit_rd(w_crd), .i_commit_entry(rob_entry_commit), .i_commit_val(rob_result_out),
    .o_value(rs1_value), .o_busy(rs1_busy), .o_tag(rs1_tag)
  );
  reg_read_port u_rs2 (
    .i_addr(rs2_addr), .i_reg_val(r_regs[rs2_addr]), .i_busy(r_busy[rs2_addr]), .i_tag(r_tag[rs2_addr]),
    .i_commit(w_commit), .i_commit_rd(w_crd), .i_commit_entry(rob_entry_commit), .i_commit_val(rob_result_out),
    .o_value(rs2_value), .o_busy(rs2_busy), .o_tag(rs2_tag)
  );
endmodule

// File: tb/tb_register_status_file.sv
// tb_register_status_file: directed table, reset sequence and randomized model check.
module tb_register_status_file;
  logic        clk_in = 0, rst_n_in = 0, rdy_in = 1, roll_back = 0, issue_valid = 0, rob_commit = 0;
  logic [4:0]  issue_rd = 0, issue_entry = 0, rs1_addr = 0, rs2_addr = 0, rob_entry_commit = 0;
  logic [5:0]  rob_des_commit = 0;
  logic [31:0] rob_result_out = 0, rs1_value, rs2_value;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rs1_tag, rs2_tag;
  int total = 0, bad = 0;

  register_status_file dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_entry(issue_entry),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rob_commit(rob_commit), .rob_des_commit(rob_des_commit), .rob_entry_commit(rob_entry_commit),
    .rob_result_out(rob_result_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic rdy, rb, iv; logic [4:0] ird, ient;
    logic cm; logic [5:0] cdes; logic [4:0] cent; logic [31:0] cres;
    logic [4:0] ra; logic [31:0] ev; logic eb; logic [4:0] et;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic rdy, rb, iv, input logic [4:0] ird, ient,
                             input logic cm, input logic [5:0] cdes, input logic [4:0] cent, input logic [31:0] cres,
                             input logic [4:0] ra, input logic [31:0] ev, input logic eb, input logic [4:0] et);
    vec_t r;
    r.rdy = rdy; r.rb = rb; r.iv = iv; r.ird = ird; r.ient = ient;
    r.cm = cm; r.cdes = cdes; r.cent = cent; r.cres = cres;
    r.ra = ra; r.ev = ev; r.eb = eb; r.et = et;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // behavioural model: plain arrays updated by the architectural rules
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [4:0]  m_tag  [32];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
  endtask

  task automatic model_read(input logic [4:0] a, output logic [31:0] val, output logic b, output logic [4:0] t);
    val = 0; b = 0; t = 0;
    if (a != 0) begin
      if (m_busy[a] && rdy_in && rob_commit && rob_des_commit[4:0] == a && rob_entry_commit == m_tag[a]) val = rob_result_out;
      else if (m_busy[a]) begin b = 1; t = m_tag[a]; val = m_regs[a]; end
      else val = m_regs[a];
    end
  endtask

  task automatic model_step();
    int rd;
    bit clr;
    rd = int'(rob_des_commit[4:0]);
    clr = 0;
    if (!rdy_in) return;
    if (rob_commit && rd != 0) begin
      m_regs[rd] = rob_result_out;
      clr = m_busy[rd] && m_tag[rd] == rob_entry_commit;
    end
    if (roll_back) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      if (clr) m_busy[rd] = 0;
      if (issue_valid && issue_rd != 0) begin m_busy[issue_rd] = 1; m_tag[issue_rd] = issue_entry; end
    end
  endtask

  task automatic idle_inputs();
    rdy_in = 1; roll_back = 0; issue_valid = 0; issue_rd = 0; issue_entry = 0;
    rob_commit = 0; rob_des_commit = 0; rob_entry_commit = 0; rob_result_out = 0;
  endtask

  task automatic chk_port(input string nm, input logic [31:0] ev, input logic eb, input logic [4:0] et);
    chk({nm, ".rs1_busy"}, {31'd0, rs1_busy}, {31'd0, eb});
    chk({nm, ".rs2_busy"}, {31'd0, rs2_busy}, {31'd0, eb});
    if (eb) begin
      chk({nm, ".rs1_tag"}, {27'd0, rs1_tag}, {27'd0, et});
      chk({nm, ".rs2_tag"}, {27'd0, rs2_tag}, {27'd0, et});
    end else begin
      chk({nm, ".rs1_value"}, rs1_value, ev);
      chk({nm, ".rs2_value"}, rs2_value, ev);
    end
  endtask

  initial begin
    logic [31:0] ev1, ev2;
    logic eb1, eb2;
    logic [4:0] et1, et2;
    idle_inputs();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1;
    #1;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(a); #0;
      chk_port($sformatf("reset_state[%0d]", a), 0, 0, 0);
    end

    //            rdy rb iv ird ient cm cdes   cent cres          ra  ev            eb et
    tbl.push_back(v(1, 0, 1, 5,  3,  0, 0,     0,   0,            5,  0,            0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            5,  0,            1, 3));
    tbl.push_back(v(1, 0, 0, 0,  0,  1, 6'h25, 3,   32'hDEAD,     5,  32'hDEAD,     0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            5,  32'hDEAD,     0, 0));
    tbl.push_back(v(1, 0, 1, 7,  2,  0, 0,     0,   0,            7,  0,            0, 0));
    tbl.push_back(v(1, 0, 1, 7,  9,  0, 0,     0,   0,            7,  0,            1, 2));
    tbl.push_back(v(1, 0, 0, 0,  0,  1, 7,     2,   32'h11,       7,  0,            1, 9));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            7,  0,            1, 9));
    tbl.push_back(v(1, 0, 1, 4,  1,  0, 0,     0,   0,            4,  0,            0, 0));
    tbl.push_back(v(1, 0, 1, 4,  6,  1, 4,     1,   32'h55,       4,  32'h55,       0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            4,  0,            1, 6));
    tbl.push_back(v(1, 0, 1, 1,  10, 0, 0,     0,   0,            1,  0,            0, 0));
    tbl.push_back(v(1, 0, 1, 2,  11, 0, 0,     0,   0,            1,  0,            1, 10));
    tbl.push_back(v(1, 0, 1, 3,  12, 0, 0,     0,   0,            2,  0,            1, 11));
    tbl.push_back(v(1, 1, 1, 8,  13, 1, 1,     10,  32'h99,       3,  0,            1, 12));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            1,  32'h99,       0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            8,  0,            0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            7,  32'h11,       0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            4,  32'h55,       0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            3,  0,            0, 0));
    tbl.push_back(v(1, 0, 1, 0,  5,  1, 0,     0,   32'hFF,       0,  0,            0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            0,  0,            0, 0));
    tbl.push_back(v(0, 0, 1, 9,  4,  0, 0,     0,   0,            9,  0,            0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            9,  0,            0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0,  1, 5,     0,   32'h77,       5,  32'hDEAD,     0, 0));
    tbl.push_back(v(1, 0, 1, 6,  7,  0, 0,     0,   0,            5,  32'hDEAD,     0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0,  1, 6,     7,   32'h66,       6,  0,            1, 7));
    tbl.push_back(v(0, 1, 0, 0,  0,  0, 0,     0,   0,            6,  0,            1, 7));
    tbl.push_back(v(1, 0, 0, 0,  0,  0, 0,     0,   0,            6,  0,            1, 7));

    foreach (tbl[i]) begin
      @(negedge clk_in);
      rdy_in = tbl[i].rdy; roll_back = tbl[i].rb; issue_valid = tbl[i].iv;
      issue_rd = tbl[i].ird; issue_entry = tbl[i].ient; rob_commit = tbl[i].cm;
      rob_des_commit = tbl[i].cdes; rob_entry_commit = tbl[i].cent; rob_result_out = tbl[i].cres;
      rs1_addr = tbl[i].ra; rs2_addr = tbl[i].ra;
      #1;
      chk_port($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eb, tbl[i].et);
    end

    // mid-run asynchronous reset discards committed values and pending tags
    @(negedge clk_in);
    idle_inputs();
    rob_commit = 1; rob_des_commit = 5; rob_result_out = 7;
    @(negedge clk_in);
    idle_inputs();
    issue_valid = 1; issue_rd = 10; issue_entry = 3;
    #2 rst_n_in = 0;
    #1;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(a); #0;
      chk_port($sformatf("in_reset[%0d]", a), 0, 0, 0);
    end
    @(posedge clk_in); #1;
    rs1_addr = 10; rs2_addr = 10; #0;
    chk_port("reset_hold_x10", 0, 0, 0);
    @(negedge clk_in);
    idle_inputs();
    rst_n_in = 1;
    #1;
    rs1_addr = 5; rs2_addr = 5; #0;
    chk_port("after_reset_x5", 0, 0, 0);
    rs1_addr = 10; rs2_addr = 10; #0;
    chk_port("after_reset_x10", 0, 0, 0);

    model_clear();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_in);
      rdy_in = $urandom_range(0, 9) != 0;
      roll_back = $urandom_range(0, 19) == 0;
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd = 5'($urandom_range(0, 7));
      issue_entry = 5'($urandom_range(0, 31));
      rob_commit = $urandom_range(0, 1) == 1;
      rob_des_commit = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))};
      rob_entry_commit = $urandom_range(0, 1) == 1 ? m_tag[rob_des_commit[4:0]] : 5'($urandom_range(0, 31));
      rob_result_out = $urandom;
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      #1;
      model_read(rs1_addr, ev1, eb1, et1);
      model_read(rs2_addr, ev2, eb2, et2);
      chk("rnd.rs1_busy", {31'd0, rs1_busy}, {31'd0, eb1});
      chk("rnd.rs2_busy", {31'd0, rs2_busy}, {31'd0, eb2});
      if (eb1) chk("rnd.rs1_tag", {27'd0, rs1_tag}, {27'd0, et1});
      else chk("rnd.rs1_value", rs1_value, ev1);
      if (eb2) chk("rnd.rs2_tag", {27'd0, rs2_tag}, {27'd0, et2});
      else chk("rnd.rs2_value", rs2_value, ev2);
      @(posedge clk_in);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
